alct_daq_rx: RTL and testbench

- Receiver/checker for the 19-bit ALCT DAQ readout stream, one word per clock.
- Frames the stream, extracts header fields, recomputes the CRC and checks frame length.
- Reports per-frame status and keeps good/bad frame counters.
- Sits at the far end of the DAQ link: in the loopback test fixture, and on the TMB-side capture path for link qualification.

---
 rtl/alct_daq_pkg.sv | 20 ++
 rtl/alct_daq_rx_if.sv | 34 +++
 rtl/alct_daq_crc22.sv | 20 ++
 rtl/alct_daq_rx.sv | 209 ++++++++++++++++++++
 tb/tb_alct_daq_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alct_daq_pkg.sv
// Shared constants and state encoding for the ALCT DAQ stream receiver.
package alct_daq_pkg;

    localparam logic [18:0] HDR_WORD = 19'h0DB0A;
    localparam logic [18:0] TRL_WORD = 19'h0DE0D;
    localparam logic [7:0]  LEN_TAG  = 8'b00111010;
    localparam logic [5:0]  BINS_TAG = 6'h5;
    localparam logic [21:0] CRC_POLY = 22'h3;
    localparam logic [3:0]  HDR_NIB  = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        CRC_LO,
        CRC_HI,
        LEN
    } state_t;

endpackage

// File: rtl/alct_daq_rx_if.sv
// DAQ stream input and per-frame status bundle between the link and the receiver.
interface alct_daq_rx_if #(
    parameter int CNT_W = 16
);
    logic [18:0]      daqp;
    logic             frame_done;
    logic             frame_ok;
    logic             crc_err;
    logic             len_err;
    logic             seq_err;
    logic [11:0]      bxn_l1a;
    logic [11:0]      l1a_cnt;
    logic [11:0]      rd_cnt;
    logic [3:0]       lct_bins;
    logic [4:0]       raw_bins;
    logic [10:0]      word_cnt;
    logic [CNT_W-1:0] good_frames;
    logic [CNT_W-1:0] bad_frames;

    modport master (
        output daqp,
        input  frame_done, frame_ok, crc_err, len_err, seq_err,
        input  bxn_l1a, l1a_cnt, rd_cnt, lct_bins, raw_bins, word_cnt,
        input  good_frames, bad_frames
    );

    modport slave (
        input  daqp,
        output frame_done, frame_ok, crc_err, len_err, seq_err,
        output bxn_l1a, l1a_cnt, rd_cnt, lct_bins, raw_bins, word_cnt,
        output good_frames, bad_frames
    );

endinterface

// File: rtl/alct_daq_crc22.sv
// One-cycle CRC-22 (x^22+x+1) update over a 16-bit word, MSB first.
module alct_daq_crc22
    import alct_daq_pkg::*;
(
    input  logic [21:0] crc_in,
    input  logic [15:0] d,
    output logic [21:0] crc_out
);

    logic [21:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            c = (c[21] ^ d[i]) ? ({c[20:0], 1'b0} ^ CRC_POLY) : {c[20:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/alct_daq_rx.sv
// ALCT DAQ frame receiver: frames the stream, checks CRC/length/sequence, reports status.
module alct_daq_rx
    import alct_daq_pkg::*;
#(
    parameter int MAX_WORDS = 2047,
    parameter int CNT_W     = 16
) (
    input logic          clk,
    input logic          hard_rst,
    alct_daq_rx_if.slave bus
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

    logic [18:0]      din;
    state_t           state, state_nxt;
    logic [21:0]      crc, crc_nxt, crc_seed, crc_step;
    logic [10:0]      cnt, cnt_nxt, cnt_inc, fin_cnt;
    logic             e_crc, e_len, e_seq;
    logic             e_crc_nxt, e_len_nxt, e_seq_nxt;
    logic             fin_crc, fin_len, fin_seq;
    logic [11:0]      s_bxn, s_l1a, s_rd, s_bxn_nxt, s_l1a_nxt, s_rd_nxt;
    logic [3:0]       s_lct, s_lct_nxt;
    logic [4:0]       s_raw, s_raw_nxt;
    logic             finish, start, is_idle, is_hdr;
    logic [CNT_W-1:0] good_q, bad_q;

    assign is_idle = din[18];
    assign is_hdr  = (din == HDR_WORD);
    assign cnt_inc = cnt + 11'd1;
    // A header seen in IDLE or interrupting BODY seeds a fresh CRC
    assign crc_seed = (state == IDLE || (state == BODY && is_hdr)) ? '0 : crc;

    alct_daq_crc22 u_crc (
        .crc_in (crc_seed),
        .d      (din[15:0]),
        .crc_out(crc_step)
    );

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        cnt_nxt   = cnt;
        e_crc_nxt = e_crc;
        e_len_nxt = e_len;
        e_seq_nxt = e_seq;
        s_bxn_nxt = s_bxn;
        s_l1a_nxt = s_l1a;
        s_rd_nxt  = s_rd;
        s_lct_nxt = s_lct;
        s_raw_nxt = s_raw;
        finish    = 1'b0;
        start     = 1'b0;

        if (state != IDLE && is_idle) begin
            e_seq_nxt = 1'b1;
            finish    = 1'b1;
        end else begin
            case (state)
                IDLE: start = is_hdr;
                HDR: begin
                    cnt_nxt = cnt_inc;
                    crc_nxt = crc_step;
                    case (cnt)
                        11'd1: s_bxn_nxt = din[11:0];
                        11'd2: s_l1a_nxt = din[11:0];
                        11'd3: s_rd_nxt  = din[11:0];
                        11'd7: begin
                            s_lct_nxt = din[8:5];
                            s_raw_nxt = din[4:0];
                            state_nxt = BODY;
                            if (din[14:9] != BINS_TAG) e_seq_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                    if (cnt <= 11'd3 && din[15:12] != HDR_NIB) e_seq_nxt = 1'b1;
                end
                BODY: begin
                    if (is_hdr) begin
                        e_seq_nxt = 1'b1;
                        finish    = 1'b1;
                        start     = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                        crc_nxt = crc_step;
                        if (din == TRL_WORD) begin
                            state_nxt = CRC_LO;
                        end else if (cnt_inc == MAX_CNT) begin
                            e_len_nxt = 1'b1;
                            finish    = 1'b1;
                        end
                    end
                end
                CRC_LO: begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = CRC_HI;
                    if (din[17:0] != {7'b0, crc[10:0]}) e_crc_nxt = 1'b1;
                end
                CRC_HI: begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = LEN;
                    if (din[17:0] != {7'b0, crc[21:11]}) e_crc_nxt = 1'b1;
                end
                LEN: begin
                    cnt_nxt = cnt_inc;
                    finish  = 1'b1;
                    if (din[18:11] != LEN_TAG) e_seq_nxt = 1'b1;
                    if (din[10:0] != cnt_inc) e_len_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Snapshot the ending frame before a same-cycle restart overwrites it
        fin_crc = e_crc_nxt;
        fin_len = e_len_nxt;
        fin_seq = e_seq_nxt;
        fin_cnt = cnt_nxt;

        if (finish) state_nxt = IDLE;
        if (start) begin
            state_nxt = HDR;
            crc_nxt   = crc_step;
            cnt_nxt   = 11'd1;
            e_crc_nxt = 1'b0;
            e_len_nxt = 1'b0;
            e_seq_nxt = 1'b0;
            // Cleared so an early abort never reports a previous frame's fields
            s_bxn_nxt = '0;
            s_l1a_nxt = '0;
            s_rd_nxt  = '0;
            s_lct_nxt = '0;
            s_raw_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (hard_rst) begin
            din            <= '0;
            state          <= IDLE;
            crc            <= '0;
            cnt            <= '0;
            e_crc          <= 1'b0;
            e_len          <= 1'b0;
            e_seq          <= 1'b0;
            s_bxn          <= '0;
            s_l1a          <= '0;
            s_rd           <= '0;
            s_lct          <= '0;
            s_raw          <= '0;
            good_q         <= '0;
            bad_q          <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_ok   <= 1'b0;
            bus.crc_err    <= 1'b0;
            bus.len_err    <= 1'b0;
            bus.seq_err    <= 1'b0;
            bus.bxn_l1a    <= '0;
            bus.l1a_cnt    <= '0;
            bus.rd_cnt     <= '0;
            bus.lct_bins   <= '0;
            bus.raw_bins   <= '0;
            bus.word_cnt   <= '0;
        end else begin
            din            <= bus.daqp;
            state          <= state_nxt;
            crc            <= crc_nxt;
            cnt            <= cnt_nxt;
            e_crc          <= e_crc_nxt;
            e_len          <= e_len_nxt;
            e_seq          <= e_seq_nxt;
            s_bxn          <= s_bxn_nxt;
            s_l1a          <= s_l1a_nxt;
            s_rd           <= s_rd_nxt;
            s_lct          <= s_lct_nxt;
            s_raw          <= s_raw_nxt;
            bus.frame_done <= finish;
            if (finish) begin
                bus.frame_ok <= !(fin_crc | fin_len | fin_seq);
                bus.crc_err  <= fin_crc;
                bus.len_err  <= fin_len;
                bus.seq_err  <= fin_seq;
                bus.bxn_l1a  <= s_bxn_nxt;
                bus.l1a_cnt  <= s_l1a_nxt;
                bus.rd_cnt   <= s_rd_nxt;
                bus.lct_bins <= s_lct_nxt;
                bus.raw_bins <= s_raw_nxt;
                bus.word_cnt <= fin_cnt;
                if (!(fin_crc | fin_len | fin_seq)) begin
                    if (good_q != '1) good_q <= good_q + CNT_W'(1);
                end else begin
                    if (bad_q != '1) bad_q <= bad_q + CNT_W'(1);
                end
            end
            // A restart in the same cycle must still report the ending frame's fields
            if (finish && start) begin
                bus.bxn_l1a  <= s_bxn;
                bus.l1a_cnt  <= s_l1a;
                bus.rd_cnt   <= s_rd;
                bus.lct_bins <= s_lct;
                bus.raw_bins <= s_raw;
            end
        end
    end

    assign bus.good_frames = good_q;
    assign bus.bad_frames  = bad_q;

endmodule

// File: tb/tb_alct_daq_rx.sv
// Randomized frame generator with a construction-driven scoreboard for alct_daq_rx.
module tb_alct_daq_rx;
    import alct_daq_pkg::*;

    localparam int MAXW = 2047;

    typedef struct packed {
        bit        ok, ce, le, se;
        bit [11:0] bxn, l1a, rd;
        bit [3:0]  lct;
        bit [4:0]  raw;
        bit [10:0] wc;
        bit [15:0] good, bad;
    } exp_t;

    logic clk = 1'b0;
    logic hard_rst;
    always #5 clk = ~clk;

    alct_daq_rx_if #(.CNT_W(16)) bus ();
    alct_daq_rx #(.MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk     (clk),
        .hard_rst(hard_rst),
        .bus     (bus.slave)
    );

    exp_t expq[$];
    int   latq[$];
    int   total = 0, bad = 0, cyc = 0;
    int   good_m = 0, bad_m = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [21:0] crc_w(input logic [21:0] c, input logic [18:0] w);
        logic [21:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = (r[21] ^ w[i]) ? ((r << 1) ^ 22'h3) : (r << 1);
        return r;
    endfunction

    function automatic logic [18:0] rdat();
        logic [18:0] w;
        do w = {3'b0, 16'($urandom)}; while (w == HDR_WORD || w == TRL_WORD);
        return w;
    endfunction

    function automatic logic [18:0] ridle();
        return {1'b1, 18'($urandom)};
    endfunction

    // Word whose registration ends a frame records when frame_done is due
    task automatic send(input logic [18:0] w, input bit term);
        @(negedge clk);
        bus.daqp = w;
        if (term) latq.push_back(cyc + 2);
    endtask

    task automatic gap(input int n);
        repeat (n) send(ridle(), 1'b0);
    endtask

    // kind: 0 good, 1 crc flip in w4, 2 len+1, 3 idle at word arg, 4 header at body
    // word arg (caller sends next frame), 5 bad w2 nibble, 6 no trailer before MAXW,
    // 7 partial frame of arg words with no expectation
    task automatic build(input int kind, input int nbody, input int arg,
                         input logic [11:0] bxn, input logic [3:0] lct,
                         input logic [4:0] raw, input bit w0_term);
        logic [18:0] f[$];
        logic [18:0] t;
        logic [21:0] c;
        logic [11:0] l1a, rd;
        exp_t e;
        int T, n;
        l1a = 12'($urandom);
        rd  = 12'($urandom);
        f.push_back(HDR_WORD);
        f.push_back({3'b0, 4'hD, bxn});
        f.push_back({3'b0, (kind == 5) ? 4'hC : 4'hD, l1a});
        f.push_back({3'b0, 4'hD, rd});
        repeat (3) f.push_back(rdat());
        f.push_back({4'b0, BINS_TAG, lct, raw});
        for (int i = 0; i < nbody; i++) f.push_back(rdat());
        f.push_back(TRL_WORD);
        T = f.size() - 1;
        c = '0;
        foreach (f[i]) c = crc_w(c, f[i]);
        f.push_back({8'b0, c[10:0]});
        f.push_back({8'b0, c[21:11]});
        f.push_back({LEN_TAG, 11'(T + 4 + ((kind == 2) ? 1 : 0))});
        if (kind == 1) begin
            t = f[4];
            t[0] = ~t[0];
            f[4] = t;
        end

        e = '0;
        e.bxn = bxn; e.l1a = l1a; e.rd = rd; e.lct = lct; e.raw = raw;
        e.wc = 11'(T + 4);
        e.ce = (kind == 1); e.le = (kind == 2); e.se = (kind == 5);
        n = f.size();
        if (kind == 3) begin
            n = arg; e.wc = 11'(arg); e.se = 1;
            if (arg <= 1) e.bxn = '0;
            if (arg <= 2) e.l1a = '0;
            if (arg <= 3) e.rd = '0;
            if (arg <= 7) begin e.lct = '0; e.raw = '0; end
        end
        if (kind == 4) begin n = 8 + arg; e.wc = 11'(n); e.se = 1; end
        if (kind == 6) begin e.wc = 11'(MAXW); e.le = 1; end
        if (kind == 7) n = arg;
        e.ok = !(e.ce | e.le | e.se);
        if (kind != 7) begin
            if (e.ok) good_m++; else bad_m++;
            e.good = 16'(good_m);
            e.bad  = 16'(bad_m);
            expq.push_back(e);
        end

        for (int i = 0; i < f.size(); i++) begin
            if (kind == 3 && i == arg) begin send(ridle(), 1'b1); break; end
            if ((kind == 4 || kind == 7) && i == n) break;
            send(f[i], (i == 0 && w0_term) || (kind != 6 && i == f.size() - 1) ||
                       (kind == 6 && i == MAXW - 1));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"}, 32'(bus.frame_done), 0);
        chk({tag, "_ok"}, 32'(bus.frame_ok), 0);
        chk({tag, "_errs"}, 32'({bus.crc_err, bus.len_err, bus.seq_err}), 0);
        chk({tag, "_fields"}, 32'(bus.bxn_l1a | bus.l1a_cnt | bus.rd_cnt), 0);
        chk({tag, "_bins"}, 32'({bus.lct_bins, bus.raw_bins}), 0);
        chk({tag, "_wcnt"}, 32'(bus.word_cnt), 0);
        chk({tag, "_good"}, 32'(bus.good_frames), 0);
        chk({tag, "_bad"}, 32'(bus.bad_frames), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int l;
        if (bus.frame_done === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", 32'(bus.frame_done), 0);
            end else begin
                e = expq.pop_front();
                l = (latq.size() > 0) ? latq.pop_front() : -1;
                chk("done_cycle", cyc, l);
                chk("frame_ok", 32'(bus.frame_ok), 32'(e.ok));
                chk("crc_err", 32'(bus.crc_err), 32'(e.ce));
                chk("len_err", 32'(bus.len_err), 32'(e.le));
                chk("seq_err", 32'(bus.seq_err), 32'(e.se));
                chk("bxn_l1a", 32'(bus.bxn_l1a), 32'(e.bxn));
                chk("l1a_cnt", 32'(bus.l1a_cnt), 32'(e.l1a));
                chk("rd_cnt", 32'(bus.rd_cnt), 32'(e.rd));
                chk("lct_bins", 32'(bus.lct_bins), 32'(e.lct));
                chk("raw_bins", 32'(bus.raw_bins), 32'(e.raw));
                chk("word_cnt", 32'(bus.word_cnt), 32'(e.wc));
                chk("good_frames", 32'(bus.good_frames), 32'(e.good));
                chk("bad_frames", 32'(bus.bad_frames), 32'(e.bad));
            end
        end
    end

    initial begin
        int k, nb, a;
        hard_rst = 1'b1;
        bus.daqp = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        hard_rst = 1'b0;

        build(0, 0, 0, 12'h123, 4'd0, 5'd0, 1'b0);     // minimal good frame, len 12
        gap(2);
        build(1, 0, 0, 12'h123, 4'd0, 5'd0, 1'b0);     // crc error
        gap(1);
        build(2, 0, 0, 12'h456, 4'd3, 5'd9, 1'b0);     // length error only
        gap(2);
        build(3, 3, 5, 12'h789, 4'd1, 5'd2, 1'b0);     // idle at w5
        gap(2);
        build(4, 4, 1, 12'hABC, 4'd5, 5'd17, 1'b0);    // header at word 9
        build(0, 2, 0, 12'h321, 4'd7, 5'd31, 1'b1);    // back-to-back good frame
        build(5, 1, 0, 12'h0F0, 4'd2, 5'd4, 1'b0);     // bad w2 nibble, no gap
        gap(3);

        // Reset in the middle of a body discards the frame and clears everything
        build(7, 20, 12, 12'h555, 4'd1, 5'd1, 1'b0);
        @(negedge clk);
        hard_rst = 1'b1;
        bus.daqp = HDR_WORD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_zero("in_reset");
            bus.daqp = (i == 1) ? TRL_WORD : rdat();
        end
        good_m = 0;
        bad_m  = 0;
        hard_rst = 1'b0;
        bus.daqp = ridle();
        build(0, 3, 0, 12'h2A5, 4'd9, 5'd6, 1'b0);
        gap(2);

        for (int r = 0; r < 40; r++) begin
            k  = $urandom_range(0, 5);
            nb = $urandom_range(0, 6);
            a  = 0;
            if (k == 4 && nb == 0) nb = 1;
            if (k == 3) a = $urandom_range(1, 8 + nb + 3);
            if (k == 4) a = $urandom_range(0, nb - 1);
            build(k, nb, a, 12'($urandom), 4'($urandom), 5'($urandom), 1'b0);
            if (k == 4) build(0, $urandom_range(0, 4), 0, 12'($urandom), 4'($urandom),
                              5'($urandom), 1'b1);
            gap($urandom_range(0, 2));
        end

        build(6, MAXW, 0, 12'h777, 4'd4, 5'd8, 1'b0);  // runaway frame hits MAXW
        gap(1);
        build(0, 1, 0, 12'h888, 4'd6, 5'd10, 1'b0);
        gap(6);
        chk("pending_frames", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
